// File: rtl/core_pkg.sv
// core_pkg: control-word types, writeback/load-width encodings and the
// pipeline bubble shared by the ID/EX and EX/MEM registers.
package core_pkg;
    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_CMP  = 2'b01,
        WB_PC4  = 2'b10,
        WB_LOAD = 2'b11
    } wb_type_e;
    typedef enum logic [1:0] {
        EXT_BYTE = 2'b00,
        EXT_HALF = 2'b01,
        EXT_WORD = 2'b10
    } dram_ext_e;
    typedef struct packed {
        logic      we_reg;
        logic      rd2_imm_sel;
        logic      rd1_pc_sel;
        logic      unsigned_sel;
        logic      we_dram;
        logic      is_load;
        logic [3:0] alu_sel;
        logic [1:0] comp_sel;
        wb_type_e  wb_type;
        dram_ext_e dram_extend;
    } ctrl_t;
    localparam ctrl_t CTRL_BUBBLE = '{
        we_reg: 1'b0, rd2_imm_sel: 1'b0, rd1_pc_sel: 1'b0, unsigned_sel: 1'b0,
        we_dram: 1'b0, is_load: 1'b0, alu_sel: 4'd0, comp_sel: 2'd0,
        wb_type: WB_ALU, dram_extend: EXT_WORD
    };
endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: decode-side fields in, execute-side fields and hazard status out.
interface id_ex_stage_if #(parameter int XLEN = 32, parameter int CNT_W = 16);
    logic            id_valid, ex_valid;
    logic [XLEN-1:0] id_pc, id_rd1, id_rd2, id_imm;
    logic [XLEN-1:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
    logic [4:0]      id_rs1, id_rs2, id_rd, ex_rs1, ex_rs2, ex_rd;
    logic            id_use_rs1, id_use_rs2, ex_use_rs1, ex_use_rs2;
    logic            id_we_reg, id_rd2_imm_sel, id_rd1_pc_sel, id_unsigned_sel, id_we_dram, id_is_load;
    logic            ex_we_reg, ex_rd2_imm_sel, ex_rd1_pc_sel, ex_unsigned_sel, ex_we_dram, ex_is_load;
    logic [3:0]      id_alu_sel, ex_alu_sel;
    logic [1:0]      id_comp_sel, id_wb_type, id_dram_extend;
    logic [1:0]      ex_comp_sel, ex_wb_type, ex_dram_extend;
    logic            ex_flush, stall;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    modport master (
        output id_valid, id_pc, id_rd1, id_rd2, id_imm, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
               id_we_reg, id_rd2_imm_sel, id_rd1_pc_sel, id_unsigned_sel, id_we_dram, id_is_load,
               id_alu_sel, id_comp_sel, id_wb_type, id_dram_extend, ex_flush,
        input  ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_use_rs1, ex_use_rs2,
               ex_we_reg, ex_rd2_imm_sel, ex_rd1_pc_sel, ex_unsigned_sel, ex_we_dram, ex_is_load,
               ex_alu_sel, ex_comp_sel, ex_wb_type, ex_dram_extend, stall, stall_cnt, flush_cnt
    );
    modport slave (
        input  id_valid, id_pc, id_rd1, id_rd2, id_imm, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
               id_we_reg, id_rd2_imm_sel, id_rd1_pc_sel, id_unsigned_sel, id_we_dram, id_is_load,
               id_alu_sel, id_comp_sel, id_wb_type, id_dram_extend, ex_flush,
        output ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_use_rs1, ex_use_rs2,
               ex_we_reg, ex_rd2_imm_sel, ex_rd1_pc_sel, ex_unsigned_sel, ex_we_dram, ex_is_load,
               ex_alu_sel, ex_comp_sel, ex_wb_type, ex_dram_extend, stall, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/id_ex_stage_load_use_detect.sv
// load_use_detect: flags an ID instruction that reads the register a load in EX is still fetching.
module load_use_detect (
    input  logic       id_valid_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_use_rs1_i,
    input  logic       id_use_rs2_i,
    input  logic       ex_valid_i,
    input  logic       ex_is_load_i,
    input  logic [4:0] ex_rd_i,
    output logic       hazard_o
);
    assign hazard_o = id_valid_i & ex_valid_i & ex_is_load_i & (ex_rd_i != 5'd0) &
                      ((id_use_rs1_i & (id_rs1_i == ex_rd_i)) | (id_use_rs2_i & (id_rs2_i == ex_rd_i)));
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, EX redirect flush
// and saturating stall/flush event counters.
module id_ex_stage
    import core_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input logic          clk,
    input logic          rst_n,
    id_ex_stage_if.slave bus
);
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc, rd1, rd2, imm;
        logic [4:0]      rs1, rs2, rd;
        logic            use_rs1, use_rs2;
        ctrl_t           ctrl;
    } stage_t;
    stage_t stage_d, stage_q;
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q, flush_cnt_d, flush_cnt_q;
    logic hazard;
    load_use_detect u_lud (
        .id_valid_i   (bus.id_valid),
        .id_rs1_i     (bus.id_rs1),
        .id_rs2_i     (bus.id_rs2),
        .id_use_rs1_i (bus.id_use_rs1),
        .id_use_rs2_i (bus.id_use_rs2),
        .ex_valid_i   (stage_q.valid),
        .ex_is_load_i (stage_q.ctrl.is_load),
        .ex_rd_i      (stage_q.rd),
        .hazard_o     (hazard)
    );
    assign bus.stall = hazard & ~bus.ex_flush;
    // Flush, hazard and an empty ID slot all collapse to the same bubble.
    always_comb begin
        stage_d      = '0;
        stage_d.ctrl = CTRL_BUBBLE;
        if (!(bus.ex_flush | hazard | ~bus.id_valid))
            stage_d = '{valid: 1'b1, pc: bus.id_pc, rd1: bus.id_rd1, rd2: bus.id_rd2, imm: bus.id_imm,
                        rs1: bus.id_rs1, rs2: bus.id_rs2, rd: bus.id_rd,
                        use_rs1: bus.id_use_rs1, use_rs2: bus.id_use_rs2,
                        ctrl: '{we_reg: bus.id_we_reg, rd2_imm_sel: bus.id_rd2_imm_sel,
                                rd1_pc_sel: bus.id_rd1_pc_sel, unsigned_sel: bus.id_unsigned_sel,
                                we_dram: bus.id_we_dram, is_load: bus.id_is_load,
                                alu_sel: bus.id_alu_sel, comp_sel: bus.id_comp_sel,
                                wb_type: wb_type_e'(bus.id_wb_type),
                                dram_extend: dram_ext_e'(bus.id_dram_extend)}};
        stall_cnt_d = (bus.stall & ~&stall_cnt_q) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
        flush_cnt_d = (bus.ex_flush & ~&flush_cnt_q) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q      <= '0;
            stage_q.ctrl <= CTRL_BUBBLE;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            stage_q     <= stage_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
    assign bus.ex_valid        = stage_q.valid;
    assign bus.ex_pc           = stage_q.pc;
    assign bus.ex_rd1          = stage_q.rd1;
    assign bus.ex_rd2          = stage_q.rd2;
    assign bus.ex_imm          = stage_q.imm;
    assign bus.ex_rs1          = stage_q.rs1;
    assign bus.ex_rs2          = stage_q.rs2;
    assign bus.ex_rd           = stage_q.rd;
    assign bus.ex_use_rs1      = stage_q.use_rs1;
    assign bus.ex_use_rs2      = stage_q.use_rs2;
    assign bus.ex_we_reg       = stage_q.ctrl.we_reg;
    assign bus.ex_rd2_imm_sel  = stage_q.ctrl.rd2_imm_sel;
    assign bus.ex_rd1_pc_sel   = stage_q.ctrl.rd1_pc_sel;
    assign bus.ex_unsigned_sel = stage_q.ctrl.unsigned_sel;
    assign bus.ex_we_dram      = stage_q.ctrl.we_dram;
    assign bus.ex_is_load      = stage_q.ctrl.is_load;
    assign bus.ex_alu_sel      = stage_q.ctrl.alu_sel;
    assign bus.ex_comp_sel     = stage_q.ctrl.comp_sel;
    assign bus.ex_wb_type      = stage_q.ctrl.wb_type;
    assign bus.ex_dram_extend  = stage_q.ctrl.dram_extend;
    assign bus.stall_cnt       = stall_cnt_q;
    assign bus.flush_cnt       = flush_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed scenarios plus random traffic against a behavioural ID/EX model.
module tb_id_ex_stage;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;
    typedef struct packed {
        logic        v;
        logic [31:0] pc, rd1, rd2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic        u1, u2, we, isel, psel, uns, wd, ld;
        logic [3:0]  alu;
        logic [1:0]  comp, wb, ext;
    } ins_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_chk = 0, n_pass = 0;
    ins_t cur, m;
    int m_sc, m_fc;
    bit hold;
    id_ex_stage_if #(.XLEN(32), .CNT_W(CW)) bus ();
    id_ex_stage #(.XLEN(32), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(string n, logic [255:0] got, logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", n, got, exp, $time);
    endtask
    function automatic ins_t bub();
        ins_t b = '0;
        b.ext = 2'b10;
        return b;
    endfunction
    function automatic ins_t ex_now();
        return '{v: bus.ex_valid, pc: bus.ex_pc, rd1: bus.ex_rd1, rd2: bus.ex_rd2, imm: bus.ex_imm,
                 rs1: bus.ex_rs1, rs2: bus.ex_rs2, rd: bus.ex_rd, u1: bus.ex_use_rs1, u2: bus.ex_use_rs2,
                 we: bus.ex_we_reg, isel: bus.ex_rd2_imm_sel, psel: bus.ex_rd1_pc_sel,
                 uns: bus.ex_unsigned_sel, wd: bus.ex_we_dram, ld: bus.ex_is_load, alu: bus.ex_alu_sel,
                 comp: bus.ex_comp_sel, wb: bus.ex_wb_type, ext: bus.ex_dram_extend};
    endfunction
    // A real ID instruction reading the destination of a valid non-x0 load in EX.
    function automatic bit m_hazard();
        return cur.v && m.v && m.ld && m.rd != 0 && ((cur.u1 && cur.rs1 == m.rd) || (cur.u2 && cur.rs2 == m.rd));
    endfunction
    function automatic int sat(int c);
        return c == CMAX ? CMAX : c + 1;
    endfunction
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m = bub();
            m_sc = 0;
            m_fc = 0;
        end else begin
            if (m_hazard() && !bus.ex_flush) m_sc = sat(m_sc);
            if (bus.ex_flush) m_fc = sat(m_fc);
            m = (bus.ex_flush || m_hazard() || !cur.v) ? bub() : cur;
        end
    end
    always @(negedge clk) begin
        chk("ex_fields", ex_now(), m);
        chk("stall", bus.stall, m_hazard() && !bus.ex_flush);
        chk("counters", {bus.stall_cnt, bus.flush_cnt}, {CW'(m_sc), CW'(m_fc)});
    end
    task automatic drv(ins_t i);
        cur = i;
        bus.id_valid = i.v; bus.id_pc = i.pc; bus.id_rd1 = i.rd1; bus.id_rd2 = i.rd2; bus.id_imm = i.imm;
        bus.id_rs1 = i.rs1; bus.id_rs2 = i.rs2; bus.id_rd = i.rd;
        bus.id_use_rs1 = i.u1; bus.id_use_rs2 = i.u2; bus.id_we_reg = i.we;
        bus.id_rd2_imm_sel = i.isel; bus.id_rd1_pc_sel = i.psel; bus.id_unsigned_sel = i.uns;
        bus.id_we_dram = i.wd; bus.id_is_load = i.ld; bus.id_alu_sel = i.alu;
        bus.id_comp_sel = i.comp; bus.id_wb_type = i.wb; bus.id_dram_extend = i.ext;
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    function automatic ins_t mk(logic [31:0] pc, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                                bit u1, bit u2, bit ld);
        ins_t i = '0;
        i.v = 1; i.pc = pc; i.rs1 = rs1; i.rs2 = rs2; i.rd = rd; i.u1 = u1; i.u2 = u2;
        i.we = 1; i.ld = ld; i.isel = ld; i.imm = 32'h4;
        i.wb = ld ? 2'b11 : 2'b00; i.ext = 2'b10;
        return i;
    endfunction
    function automatic ins_t rnd();
        ins_t i;
        i.v = $urandom_range(0, 7) != 0;
        i.pc = $urandom; i.rd1 = $urandom; i.rd2 = $urandom; i.imm = $urandom;
        i.rs1 = 5'($urandom_range(0, 3)); i.rs2 = 5'($urandom_range(0, 3)); i.rd = 5'($urandom_range(0, 3));
        {i.u1, i.u2, i.we, i.isel, i.psel, i.uns, i.wd} = 7'($urandom);
        i.ld = $urandom_range(0, 2) == 0;
        i.alu = 4'($urandom); i.comp = 2'($urandom); i.wb = 2'($urandom); i.ext = 2'($urandom);
        return i;
    endfunction
    initial begin
        ins_t t;
        m = bub(); m_sc = 0; m_fc = 0;
        bus.ex_flush = 0;
        t = '0; t.v = 1; t.we = 1;
        drv(t);
        @(negedge clk);
        chk("rst_valid", bus.ex_valid, 0);
        chk("rst_we_reg", bus.ex_we_reg, 0);
        chk("rst_ext", bus.ex_dram_extend, 2'b10);
        chk("rst_cnts", {bus.stall_cnt, bus.flush_cnt}, 0);
        chk("rst_stall", bus.stall, 0);
        @(posedge clk); #1 rst_n = 1;
        drv(mk(32'h10, 5'd1, 5'd0, 5'd2, 1, 0, 0));
        step();
        chk("addi_pc", bus.ex_pc, 32'h10);
        chk("addi_valid", bus.ex_valid, 1);
        drv(mk(32'h20, 5'd1, 5'd0, 5'd5, 1, 0, 1));
        step();
        drv(mk(32'h24, 5'd5, 5'd7, 5'd6, 1, 1, 0));
        #1 chk("lu_stall", bus.stall, 1);
        step();
        chk("lu_bubble", bus.ex_valid, 0);
        chk("lu_release", bus.stall, 0);
        chk("lu_cnt", bus.stall_cnt, 1);
        step();
        chk("lu_add_pc", bus.ex_pc, 32'h24);
        chk("lu_add_valid", bus.ex_valid, 1);
        drv(mk(32'h28, 5'd1, 5'd0, 5'd0, 1, 0, 1));
        step();
        drv(mk(32'h2c, 5'd0, 5'd0, 5'd3, 1, 1, 0));
        #1 chk("x0_stall", bus.stall, 0);
        step();
        drv(mk(32'h30, 5'd1, 5'd0, 5'd5, 1, 0, 1));
        step();
        drv(mk(32'h34, 5'd5, 5'd5, 5'd5, 0, 0, 0));
        #1 chk("lui_stall", bus.stall, 0);
        step();
        chk("nofalse_cnt", bus.stall_cnt, 1);
        rst_n = 0;
        step();
        rst_n = 1;
        drv(mk(32'h40, 5'd1, 5'd0, 5'd5, 1, 0, 1));
        step();
        drv(mk(32'h44, 5'd5, 5'd0, 5'd6, 1, 0, 0));
        bus.ex_flush = 1;
        #1 chk("fl_stall", bus.stall, 0);
        step();
        chk("fl_bubble", bus.ex_valid, 0);
        chk("fl_cnts", {bus.stall_cnt, bus.flush_cnt}, {4'd0, 4'd1});
        repeat (20) step();
        chk("sat_flush", bus.flush_cnt, 4'hF);
        step();
        chk("sat_hold", bus.flush_cnt, 4'hF);
        bus.ex_flush = 0;
        drv(mk(32'h50, 5'd1, 5'd0, 5'd7, 1, 0, 1));
        step();
        drv(mk(32'h54, 5'd2, 5'd7, 5'd8, 0, 1, 0));
        #1 chk("ar_stall_pre", bus.stall, 1);
        #1 rst_n = 0;
        #1 chk("ar_stall", bus.stall, 0);
        chk("ar_valid", bus.ex_valid, 0);
        step();
        rst_n = 1;
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (i == 1500) begin
                rst_n = 0;
                step();
                rst_n = 1;
            end
            if (!hold) drv(rnd());
            bus.ex_flush = $urandom_range(0, 9) == 0;
            #1 hold = bus.stall;
        end
        step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline register for the five-stage RV32I core. It latches the decoded control word (from the control unit) together with operands, immediate, PC and register indices. It detects load-use hazards between the instruction in EX and the one in ID, stalls the front end and inserts a bubble. It also accepts an EX-stage redirect flush and keeps saturating stall/flush event counters for the trace bench.

## Interface
- `XLEN`, 32, datapath width for pc/rd1/rd2/imm.
- `CNT_W`, 16, width of each event counter.

- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `id_valid`  in  1  ID holds a real instruction.
- `id_pc`, `id_rd1`, `id_rd2`, `id_imm`  in  XLEN each  decode-stage PC, register-file read data and generated immediate.
- `id_rs1`, `id_rs2`, `id_rd`  in  5 each  register indices.
- `id_use_rs1`, `id_use_rs2`  in  1 each  the ID instruction actually reads rs1/rs2.
- `id_we_reg`, `id_rd2_imm_sel`, `id_rd1_pc_sel`, `id_unsigned_sel`, `id_we_dram`, `id_is_load`  in  1 each  control bits.
- `id_alu_sel`  in  4  ALU select.
- `id_comp_sel`, `id_wb_type`, `id_dram_extend`  in  2 each  comparator select, writeback type, load/store width.
- `ex_flush`  in  1  EX resolved a taken branch or jump; kill the ID instruction.
- `ex_*`  out  same widths  registered copies of every `id_*` field above, including `ex_valid`.
- `stall`  out  1  hold PC and IF/ID this cycle.
- `stall_cnt`, `flush_cnt`  out  CNT_W each  saturating event counters.

## Operation
- **Hazard condition:** `ex_valid & ex_is_load & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)) & id_valid`.
- **`stall` output:** `stall = hazard & ~ex_flush`. It is combinational and goes to PC and IF/ID enables.
- **Update priority each edge:**
  - `ex_flush`: load a bubble.
  - otherwise a hazard: load a bubble.
  - otherwise: capture all `id_*` fields.
- **Bubble contents:** `ex_valid`, `ex_we_reg`, `ex_we_dram` and `ex_is_load` are 0. All other fields are 0, except `ex_dram_extend = 2'b10` (word) and `ex_wb_type = 2'b00` (ALU result).
- **Invalid ID:** `id_valid = 0` captures as a bubble; the control bits are not forwarded.
- **Hazard length:** a load-use hazard lasts exactly one cycle. After the bubble, EX holds no load, so the stalled ID instruction advances on the next edge.
- **Back-to-back loads:** a load followed by a dependent load stalls once per dependency.
- **Counters:**
  - `stall_cnt` increments on each edge where `stall = 1`.
  - `flush_cnt` increments on each edge where `ex_flush = 1`.
  - Both saturate at all-ones; no wrap-around.
- **x0:** rd index 0 never causes a hazard, even for a load.

## Timing
- **Reset:** asserting `rst_n` low immediately (asynchronously) forces every `ex_*` output to the bubble value, and both counters to 0.
  - `stall` is 0 while in reset, because `ex_valid = 0`.
  - Reset mid-stall drops the stall immediately.
- **Latency:** one cycle from ID to EX for a non-stalled instruction.
- **Stall path:** combinational from the `id_*` indices and the `ex_*` registers to `stall`. No combinational path from `ex_flush` to any `ex_*` output.
- **Simultaneous `ex_flush` and hazard:** flush wins. `stall = 0`, a bubble is loaded, and `flush_cnt` increments while `stall_cnt` does not.
- **Release after reset:** deasserting `rst_n` synchronously to `clk` is the SoC reset controller's responsibility. The first capture happens on the first rising edge after release.

## Structure
- **Shared package `core_pkg`:**
  - bubble constant for the control word;
  - WB_type encodings (ALU = 00, compare = 01, PC+4 = 10, load = 11);
  - dram_extend encodings (byte = 00, half = 01, word = 10);
  - a packed control-word struct so that ID/EX and EX/MEM share one definition.
- **Sub-module `load_use_detect`:** purely combinational; inputs are the ID indices and use flags plus `ex_valid`/`ex_is_load`/`ex_rd`, and the output is `hazard`. The register bank and counters stay in `id_ex_stage`.

## Test plan
- **Reset:** hold `rst_n = 0` with `id_valid = 1` and `id_we_reg = 1`.
  - Expect `ex_valid = 0`, `ex_we_reg = 0`, `ex_dram_extend = 2'b10`, counters 0, `stall = 0`.
  - Release and apply `addi` pc = 0x0000_0010; after one edge expect `ex_pc = 0x10`, `ex_valid = 1`.
- **Load-use:** issue `lw x5` (pc 0x20), then `add x6, x5, x7`.
  - Expect `stall = 1` for one cycle, a bubble in EX, then the `add` in EX at pc 0x24.
  - Expect `stall_cnt = 1`.
- **No false hazard:** `lw x0` followed by a user of x0, and `lw x5` followed by `lui x5` (`id_use_rs1 = 0`). Expect `stall = 0` and `stall_cnt` unchanged in both cases.
- **Flush priority:** a load-use hazard present and `ex_flush = 1` in the same cycle.
  - Expect `stall = 0` and a bubble loaded.
  - Expect `flush_cnt = 1`, `stall_cnt = 0`.
- **Saturation:** with CNT_W = 4, force 20 consecutive flushes. Expect `flush_cnt = 4'hF`, holding.
- **Async reset mid-stall:** while `stall = 1`, drop `rst_n` between edges. Expect `stall` and `ex_valid` to go to 0 before the next rising edge.
